// File: rtl/clk_phase_en_gen_if.sv
// rtl/clk_phase_en_gen_if.sv - divide-ratio load port of the phase enable generator
//
// Purpose: carries the ready/valid divide-ratio load handshake and reports back
//          the ratio currently in effect.
// Signals:
//   div_val  requested divide ratio N (master -> slave)
//   div_load valid for div_val        (master -> slave)
//   div_rdy  load accepted when div_load && div_rdy (slave -> master)
//   cur_div  divide ratio currently in effect        (slave -> master)
interface clk_phase_en_gen_if #(
   parameter int CNT_W = 8
) ();

   logic [CNT_W-1:0] div_val;
   logic             div_load;
   logic             div_rdy;
   logic [CNT_W-1:0] cur_div;

   modport master (
      output div_val,
      output div_load,
      input  div_rdy,
      input  cur_div
   );

   modport slave (
      input  div_val,
      input  div_load,
      output div_rdy,
      output cur_div
   );

endinterface

// File: rtl/clk_phase_en_gen.sv
// rtl/clk_phase_en_gen.sv - programmable two-phase single-cycle clock-enable generator
//
// Purpose: produces non-overlapping single-cycle enables ph1_en / ph2_en on the
//          free-running clk_in at a divide ratio N, so downstream logic stays on
//          clk_in instead of using gated derived clocks. The ratio is reloaded
//          only at period boundaries.
// Ports:
//   clk_in  sole clock, rising edge
//   reset   synchronous active-low reset
//   run     level request to generate enables
//   ld_if   divide-ratio load port (div_val/div_load/div_rdy/cur_div)
//   busy    high while running or finishing the last period
//   ph1_en  pulse at period count 0
//   ph2_en  pulse at period count floor(N/2)
module clk_phase_en_gen #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                run,
   clk_phase_en_gen_if.slave   ld_if,
   output logic                busy,
   output logic                ph1_en,
   output logic                ph2_en
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;

   logic             accept;
   logic [CNT_W-1:0] div_clamped;
   logic             at_boundary;

   // The single pending slot doubles as the handshake throttle: while it is
   // occupied no further load can be accepted.
   assign accept      = ld_if.div_load && !pend_vld_q;

   // Ratios below 2 would make floor(N/2) collide with count 0.
   assign div_clamped = (ld_if.div_val < MIN_DIV) ? MIN_DIV : ld_if.div_val;

   // Last cycle of a period; cnt_q never exceeds cur_div_q-1 because the ratio
   // only changes while the counter restarts at 0.
   assign at_boundary = (state_q != ST_IDLE) && (cnt_q == (cur_div_q - ONE));

   // State register
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cur_div_q  <= DEF_DIV_C;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!run) state_d = ST_STOPPING;
         end
         ST_STOPPING: begin
            // A re-raised run wins over the boundary so the pattern continues
            // without a gap.
            if (run)              state_d = ST_RUN;
            else if (at_boundary) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter and divide-ratio datapath
   always_comb begin
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;

      if (state_q == ST_IDLE) begin
         cnt_d = '0;
         // A load that arrived in the final boundary cycle before stopping is
         // still waiting here; apply it on the first idle cycle.
         if (pend_vld_q) begin
            cur_div_d  = pend_q;
            pend_vld_d = 1'b0;
         end else if (accept) begin
            cur_div_d = div_clamped;
         end
      end else begin
         if (at_boundary) begin
            cnt_d = '0;
            if (pend_vld_q) begin
               cur_div_d  = pend_q;
               pend_vld_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
         // accept needs an empty slot, so a load taken in a boundary cycle
         // never competes with the apply above and waits one more period.
         if (accept) begin
            pend_d     = div_clamped;
            pend_vld_d = 1'b1;
         end
      end
   end

   // Output decode, purely from registered state
   always_comb begin
      busy          = (state_q != ST_IDLE);
      ph1_en        = busy && (cnt_q == '0);
      ph2_en        = busy && (cnt_q == (cur_div_q >> 1));
      ld_if.div_rdy = !pend_vld_q;
      ld_if.cur_div = cur_div_q;
   end

endmodule

// File: tb/tb_clk_phase_en_gen.sv
// tb/tb_clk_phase_en_gen.sv - scoreboard bench for clk_phase_en_gen
module tb_clk_phase_en_gen;

   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 2;

   logic clk_in = 1'b0;
   logic reset;
   logic run;
   logic busy, ph1_en, ph2_en;

   clk_phase_en_gen_if #(.CNT_W(CNT_W)) bus ();

   clk_phase_en_gen #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .run    (run),
      .ld_if  (bus.slave),
      .busy   (busy),
      .ph1_en (ph1_en),
      .ph2_en (ph2_en)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // expected {busy, ph1_en, ph2_en, div_rdy, cur_div}
   logic [11:0] exp_q[$];

   // Reference model: an "active" generator walking position p through a
   // period of n cycles, with at most one queued ratio.
   bit m_active = 0;
   bit m_stop   = 0;
   int m_p      = 0;
   int m_n      = DEF_DIV;
   int m_pend[$];

   always @(posedge clk_in) begin
      bit rdy, acc, last;
      int val;
      logic [11:0] e;
      cyc++;
      if (reset !== 1'b1) begin
         m_active = 0; m_stop = 0; m_p = 0; m_n = DEF_DIV;
         m_pend.delete();
      end else begin
         rdy = (m_pend.size() == 0);
         acc = bus.div_load && rdy;
         val = (int'(bus.div_val) < 2) ? 2 : int'(bus.div_val);
         if (!m_active) begin
            if (m_pend.size() != 0) m_n = m_pend.pop_front();
            else if (acc)           m_n = val;
            m_active = run;
            m_stop   = 0;
            m_p      = 0;
         end else begin
            last = (m_p == m_n - 1);
            if (last) begin
               if (m_pend.size() != 0) m_n = m_pend.pop_front();
               m_p = 0;
               if (m_stop && !run) m_active = 0;
            end else begin
               m_p = m_p + 1;
            end
            if (acc) m_pend.push_back(val);
            m_stop = m_active && !run;
         end
      end
      e = {m_active, m_active && (m_p == 0), m_active && (m_p == m_n / 2),
           (m_pend.size() == 0), 8'(m_n)};
      exp_q.push_back(e);
   end

   // Monitor: compares whatever the DUT presents against the queued expectation.
   always @(negedge clk_in) begin
      logic [11:0] e, g;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         g = {busy, ph1_en, ph2_en, bus.div_rdy, bus.cur_div};
         checks++;
         if (g !== e)
            begin
               errors++;
               $display("FAIL outputs cyc=%0d got busy=%b ph1=%b ph2=%b rdy=%b cur_div=%0d required busy=%b ph1=%b ph2=%b rdy=%b cur_div=%0d",
                        cyc, g[11], g[10], g[9], g[8], g[7:0], e[11], e[10], e[9], e[8], e[7:0]);
            end
      end
   end

   task automatic step(input logic r, input logic ld, input int dv, input logic rs, input int n);
      for (int i = 0; i < n; i++) begin
         run          = r;
         bus.div_load = ld;
         bus.div_val  = 8'(dv);
         reset        = rs;
         @(negedge clk_in);
      end
   endtask

   initial begin
      run = 1'b0; reset = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
      @(negedge clk_in);
      step(0, 0, 0, 0, 3);              // reset
      step(0, 0, 0, 1, 2);              // idle after reset
      step(1, 0, 0, 1, 10);             // DEF_DIV=2 alternation
      step(0, 0, 0, 1, 6);              // stop
      step(0, 1, 5, 1, 1);              // idle load 5
      step(1, 0, 0, 1, 17);             // run at N=5
      step(1, 1, 6, 1, 1);              // queue N=6
      step(1, 0, 0, 1, 13);
      step(1, 1, 3, 1, 1);              // mid-period load 3 at N=6
      step(1, 1, 9, 1, 2);              // ignored while pending
      step(1, 0, 0, 1, 12);
      step(1, 1, 4, 1, 1);              // switch to N=4
      step(1, 0, 0, 1, 9);
      step(0, 0, 0, 1, 2);              // drop run, STOPPING
      step(1, 0, 0, 1, 6);              // re-raise seamlessly
      step(0, 0, 0, 1, 10);             // let it stop
      step(0, 1, 0, 1, 1);              // clamp 0 -> 2
      step(0, 0, 0, 1, 1);
      step(0, 1, 1, 1, 1);              // clamp 1 -> 2
      step(1, 0, 0, 1, 5);
      step(1, 1, 7, 1, 1);              // pending 7
      step(1, 1, 9, 1, 1);              // rejected
      step(0, 1, 3, 1, 3);              // stop with pending, late loads
      step(0, 0, 0, 1, 12);
      step(1, 1, 6, 1, 1);
      step(1, 0, 0, 1, 3);
      step(1, 1, 5, 1, 1);              // pending when reset hits
      step(1, 0, 0, 0, 1);              // reset mid-period
      step(0, 0, 0, 1, 3);
      for (int i = 0; i < 4000; i++) begin
         logic r;
         r = ($urandom_range(0, 15) == 0) ? ~run : run;
         step(r, ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12),
              ($urandom_range(0, 399) != 0), 1);
      end
      step(0, 0, 0, 1, 2);
      @(posedge clk_in);
      #1;
      if (checks < 12) begin
         errors++;
         $display("FAIL check_count got %0d required >=12", checks);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
